morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receiver counterpart of the Lab5 Morse transmitter. Watches a serial DotDashIn line clocked at the 0.5 s Morse unit rate.
- Recovers each 12-unit letter frame and decodes it back to the 3-bit letter code A..H.
- Reports the result with a one-cycle Valid or Error pulse.
- Self-timed: it does not use the transmitter's NewBitOut. It runs its own unit counter, aligned to the first rising edge of each frame.

Parameters:
- CLOCK_FREQUENCY, default 500: ClockIn frequency in Hz.
- BIT_CYCLES, default CLOCK_FREQUENCY/2: clock cycles per Morse unit (0.5 s).
- HALF_CYCLES, default BIT_CYCLES/2: delay from the detected rising edge to the first mid-unit sample.

Ports:
- ClockIn, input, 1: system clock.
- Reset, input, 1: asynchronous, active-low reset.
- DotDashIn, input, 1: serial Morse line; 1 = tone, 0 = gap. Asynchronous to ClockIn.
- Letter, output, 3: decoded letter, A=0 .. H=7. Held until the next successful decode.
- Valid, output, 1: one-cycle pulse when Letter has just been updated.
- Error, output, 1: one-cycle pulse when a complete frame matched no table entry.
- Busy, output, 1: high while a frame is being captured or decoded.
- Pattern, output, 12: last captured frame, MSB = first unit. Held until the next frame completes.

Behaviour:
- Reset values (Reset low, asynchronous): Letter=0, Valid=0, Error=0, Busy=0, Pattern=0. Internal state: state=IDLE, counters=0, shift register=0, synchronizer flops=0.
- Input path: DotDashIn passes through a 2-flop synchronizer, then an edge-detect register. A rising edge is synced=1 with prev=0.
- Code table (12 bits, MSB first, dot=1, dash=111, intra-letter gap=0, zero-padded):
  - A = 101110000000
  - B = 111010101000
  - C = 111010111010
  - D = 111010100000
  - E = 100000000000
  - F = 101011101000
  - G = 111011101000
  - H = 101010100000
- States: IDLE, ALIGN, SAMPLE, DECODE.
- IDLE:
  - Busy=0.
  - On a rising edge, load the unit counter with HALF_CYCLES-1 and go to ALIGN.
  - A line that is already high with no edge is ignored.
- ALIGN:
  - Count down. At 0, sample the synced line.
  - If the sample is 0: treat as a glitch. Return to IDLE with no pulse; Pattern is unchanged.
  - If the sample is 1: shift it in as bit 11, set the bit count to 1, load the counter with BIT_CYCLES-1, and go to SAMPLE.
- SAMPLE:
  - Count down. At 0, shift the synced line in at the LSB end (shift left), increment the bit count, and reload BIT_CYCLES-1.
  - When the 12th sample is taken, go to DECODE.
- DECODE (exactly one cycle):
  - Compare the 12-bit capture against the table and copy it to Pattern.
  - Match: Letter gets the code and Valid=1 on the next cycle.
  - No match: Letter is unchanged and Error=1 on the next cycle.
  - Then go to IDLE.
- Busy=1 in ALIGN, SAMPLE and DECODE.
- Latency: the Valid/Error pulse appears 2 (sync) + 1 (edge) + HALF_CYCLES + 11·BIT_CYCLES + 2 cycles after the DotDashIn rising edge, nominal, ±1 cycle.
- Edges seen during ALIGN or SAMPLE are ignored; there is no re-synchronisation mid-frame.
- Back-to-back frames: every legal frame ends in 0, so the next frame's leading edge is detected normally once the block is back in IDLE.
- Reset asserted mid-frame: immediate return to IDLE with all outputs cleared. A frame in progress is discarded with no pulse.
- Valid and Error are never high in the same cycle. Each is low in every cycle except the one following DECODE.
- Counter width is $clog2(BIT_CYCLES)+1 bits; the bit count is 4 bits. Neither wraps in legal operation.

Test Plan (CLOCK_FREQUENCY=20, BIT_CYCLES=10, HALF_CYCLES=5; each unit is driven for 10 clocks):
- Reset → outputs: Letter=0, Valid=0, Error=0, Busy=0, Pattern=0.
- Decode A: drive 101110000000 after idle → Pattern=0xB80, Letter=0, one Valid pulse, Busy high throughout the frame.
- Decode all letters: drive C (111010111010), then H (101010100000), then E (100000000000) back to back → Valid pulses with Letter=2, then 7, then 4, in that order.
- Invalid frame: drive 111111111111 → Error pulse, Letter keeps its previous value, Pattern=0xFFF, Valid stays 0.
- Glitch: drive a 3-cycle high pulse on DotDashIn, then 0 → block returns to IDLE, no Valid/Error pulse, Pattern unchanged.
- Reset mid-frame: assert Reset low during unit 6 of a G frame, release, then send D → no output pulse for G; D then decodes with Letter=3 and one Valid pulse.

Source files
------------

// File: rtl/morse_decoder_if.sv
// Signal bundle between a Morse line source and the decoder.
// The master drives the serial line; the slave (decoder) drives the results.
interface morse_decoder_if;
  logic        DotDashIn;
  logic [2:0]  Letter;
  logic        Valid;
  logic        Error;
  logic        Busy;
  logic [11:0] Pattern;

  modport master (
    output DotDashIn,
    input  Letter,
    input  Valid,
    input  Error,
    input  Busy,
    input  Pattern
  );

  modport slave (
    input  DotDashIn,
    output Letter,
    output Valid,
    output Error,
    output Busy,
    output Pattern
  );
endinterface

// File: rtl/morse_decoder.sv
// Self-timed Morse receiver: aligns to the first rising edge of a frame,
// samples twelve units at mid-unit, and decodes the frame to a letter A..H.
module morse_decoder #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int BIT_CYCLES      = CLOCK_FREQUENCY / 2,
  parameter int HALF_CYCLES     = BIT_CYCLES / 2
) (
  input  logic           i_ClockIn,
  input  logic           i_Reset,
  morse_decoder_if.slave bus
);

  localparam int CW          = $clog2(BIT_CYCLES) + 1;
  localparam int FRAME_BITS  = 12;
  localparam int NUM_LETTERS = 8;

  localparam logic [CW-1:0] BIT_RELOAD  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT    = 4'd11;

  // Code table, letter A in the lowest slice: dot=1, dash=111, gap=0.
  localparam logic [NUM_LETTERS*FRAME_BITS-1:0] CODE_TABLE = {
    12'b101010100000,   // H
    12'b111011101000,   // G
    12'b101011101000,   // F
    12'b100000000000,   // E
    12'b111010100000,   // D
    12'b111010111010,   // C
    12'b111010101000,   // B
    12'b101110000000    // A
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SAMPLE = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_prev;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] r_pattern;
  logic [2:0]            r_letter;
  logic                  r_valid;
  logic                  r_error;
  logic                  r_busy;

  logic                   w_rise;
  logic [NUM_LETTERS-1:0] w_hit;
  logic                   w_match;
  logic [2:0]             w_code;

  // Two-flop synchronizer for the asynchronous line, plus edge-detect history.
  always_ff @(posedge i_ClockIn or negedge i_Reset) begin
    if (!i_Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.DotDashIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  // One comparator per table entry against the captured frame.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LETTERS; gi++) begin : g_match
      assign w_hit[gi] = (r_shift == CODE_TABLE[gi*FRAME_BITS +: FRAME_BITS]);
    end
  endgenerate

  // Encode the (at most one) matching entry into its letter code.
  always_comb begin
    w_match = |w_hit;
    w_code  = 3'd0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (w_hit[i]) begin
        w_code = 3'(i);
      end
    end
  end

  // Frame capture FSM with registered outputs; Valid/Error default low so
  // each can only pulse for the single cycle after DECODE.
  always_ff @(posedge i_ClockIn or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= 4'd0;
      r_shift   <= '0;
      r_pattern <= '0;
      r_letter  <= 3'd0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_rise) begin
            r_cnt   <= HALF_RELOAD;
            r_state <= ALIGN;
            r_busy  <= 1'b1;
          end
        end

        ALIGN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_sync2) begin
            // Line dropped before mid-unit: a glitch, not a frame.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            // First unit enters at the LSB and reaches bit 11 after the
            // remaining eleven left shifts.
            r_shift   <= {{(FRAME_BITS-1){1'b0}}, 1'b1};
            r_bit_cnt <= 4'd1;
            r_cnt     <= BIT_RELOAD;
            r_state   <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift   <= {r_shift[FRAME_BITS-2:0], r_sync2};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_cnt     <= BIT_RELOAD;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= DECODE;
            end
          end
        end

        DECODE: begin
          r_pattern <= r_shift;
          if (w_match) begin
            r_letter <= w_code;
            r_valid  <= 1'b1;
          end else begin
            r_error  <= 1'b1;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Letter  = r_letter;
  assign bus.Valid   = r_valid;
  assign bus.Error   = r_error;
  assign bus.Busy    = r_busy;
  assign bus.Pattern = r_pattern;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with a 10-clock Morse unit.
module tb_morse_decoder;

  localparam int UNIT = 10;

  logic clk;
  logic rst_n;

  morse_decoder_if bus_if ();

  morse_decoder #(
    .CLOCK_FREQUENCY (20),
    .BIT_CYCLES      (10),
    .HALF_CYCLES     (5)
  ) dut (
    .i_ClockIn (clk),
    .i_Reset   (rst_n),
    .bus       (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation counters maintained by a monitor.
  int          cyc = 0;
  int          valid_cnt = 0;
  int          error_cnt = 0;
  int          both_cnt = 0;
  int          valid_cyc = 0;
  logic [2:0]  valid_letter = 3'd0;
  int          start_cyc = 0;
  int          busy_low_units = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.Valid) begin
      valid_cnt    <= valid_cnt + 1;
      valid_cyc    <= cyc;
      valid_letter <= bus_if.Letter;
    end
    if (bus_if.Error) error_cnt <= error_cnt + 1;
    if (bus_if.Valid && bus_if.Error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive twelve units, starting on a negedge; Busy is sampled mid-unit.
  task automatic send_frame(input logic [11:0] f);
    start_cyc = cyc;
    for (int u = 11; u >= 0; u--) begin
      bus_if.DotDashIn = f[u];
      repeat (UNIT / 2) @(negedge clk);
      if (!bus_if.Busy) busy_low_units++;
      repeat (UNIT - UNIT / 2) @(negedge clk);
    end
  endtask

  int v0, e0, lat;

  initial begin
    rst_n = 1'b0;
    bus_if.DotDashIn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_letter",  32'(bus_if.Letter),  32'd0);
    check("reset_valid",   32'(bus_if.Valid),   32'd0);
    check("reset_error",   32'(bus_if.Error),   32'd0);
    check("reset_busy",    32'(bus_if.Busy),    32'd0);
    check("reset_pattern", 32'(bus_if.Pattern), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Letter A
    v0 = valid_cnt; e0 = error_cnt; busy_low_units = 0;
    send_frame(12'b101110000000);
    #1;
    check("A_pattern",   32'(bus_if.Pattern), 32'hB80);
    check("A_letter",    32'(valid_letter),   32'd0);
    check("A_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("A_error_cnt", 32'(error_cnt - e0), 32'd0);
    check("A_busy",      32'(busy_low_units), 32'd0);
    lat = valid_cyc - start_cyc;
    check("A_latency",   32'(lat >= 119 && lat <= 121), 32'd1);
    check("A_letter_held", 32'(bus_if.Letter), 32'd0);

    // C, H, E back to back
    v0 = valid_cnt;
    send_frame(12'b111010111010);
    #1;
    check("C_letter", 32'(valid_letter),   32'd2);
    check("C_pattern", 32'(bus_if.Pattern), 32'hEBA);
    check("C_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    v0 = valid_cnt;
    send_frame(12'b101010100000);
    #1;
    check("H_letter", 32'(valid_letter),   32'd7);
    check("H_pattern", 32'(bus_if.Pattern), 32'hAA0);
    check("H_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    v0 = valid_cnt;
    send_frame(12'b100000000000);
    #1;
    check("E_letter", 32'(valid_letter),   32'd4);
    check("E_pattern", 32'(bus_if.Pattern), 32'h800);
    check("E_valid_cnt", 32'(valid_cnt - v0), 32'd1);

    // Invalid frame
    v0 = valid_cnt; e0 = error_cnt;
    send_frame(12'b111111111111);
    bus_if.DotDashIn = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("bad_error_cnt", 32'(error_cnt - e0), 32'd1);
    check("bad_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("bad_letter",    32'(bus_if.Letter),  32'd4);
    check("bad_pattern",   32'(bus_if.Pattern), 32'hFFF);

    // Glitch: 3-cycle pulse
    v0 = valid_cnt; e0 = error_cnt;
    repeat (10) @(negedge clk);
    bus_if.DotDashIn = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.DotDashIn = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("glitch_busy",    32'(bus_if.Busy),    32'd0);
    check("glitch_valid",   32'(valid_cnt - v0), 32'd0);
    check("glitch_error",   32'(error_cnt - e0), 32'd0);
    check("glitch_pattern", 32'(bus_if.Pattern), 32'hFFF);

    // Reset during unit 6 of G (111011101000), then D
    v0 = valid_cnt; e0 = error_cnt;
    for (int u = 11; u >= 6; u--) begin
      bus_if.DotDashIn = (u == 11 || u == 10 || u == 9 || u == 7 || u == 6);
      repeat (UNIT) @(negedge clk);
    end
    bus_if.DotDashIn = 1'b1;
    repeat (5) @(negedge clk);
    check("G_busy_before_reset", 32'(bus_if.Busy), 32'd1);
    rst_n = 1'b0;
    bus_if.DotDashIn = 1'b0;
    #1;
    check("midrst_busy",    32'(bus_if.Busy),    32'd0);
    check("midrst_letter",  32'(bus_if.Letter),  32'd0);
    check("midrst_pattern", 32'(bus_if.Pattern), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("G_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("G_no_error", 32'(error_cnt - e0), 32'd0);
    v0 = valid_cnt;
    send_frame(12'b111010100000);
    #1;
    check("D_letter",    32'(valid_letter),   32'd3);
    check("D_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("D_pattern",   32'(bus_if.Pattern), 32'hEA0);
    check("D_letter_out", 32'(bus_if.Letter), 32'd3);

    repeat (5) @(negedge clk);
    #1;
    check("valid_error_exclusive", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
